// File: rtl/pipe_multiplier_if.sv
// pipe_multiplier_if: operand/result valid-ready bundle for pipe_multiplier
interface pipe_multiplier_if #(
    parameter int BITSIZE = 16,
    parameter int CHW     = 2
);
    logic signed [BITSIZE-1:0] in1;
    logic signed [BITSIZE-1:0] in2;
    logic        [CHW-1:0]     in_ch;
    logic                      in_valid;
    logic                      in_ready;
    logic                      round_en;
    logic signed [BITSIZE-1:0] out;
    logic        [CHW-1:0]     out_ch;
    logic                      out_valid;
    logic                      out_ready;
    logic                      sat_flag;
    logic                      sat_clr;

    modport slave (
        input  in1, in2, in_ch, in_valid, round_en, out_ready, sat_clr,
        output in_ready, out, out_ch, out_valid, sat_flag
    );

    modport master (
        output in1, in2, in_ch, in_valid, round_en, out_ready, sat_clr,
        input  in_ready, out, out_ch, out_valid, sat_flag
    );
endinterface

// File: rtl/pipe_multiplier.sv
// pipe_multiplier: two-stage signed multiply, optional round-half-up, arithmetic right shift, valid/ready flow.
// Define PIPE_MULTIPLIER_SATURATE_EN to clamp out-of-range results and drive sticky sat_flag; otherwise results wrap.
module pipe_multiplier #(
    parameter int BITSIZE = 16,
    parameter int SHIFT   = BITSIZE,
    parameter int CHW     = 2
) (
    input logic              clk,
    input logic              rst,
    pipe_multiplier_if.slave bus
);
    localparam int W = 2 * BITSIZE + 1;
    localparam logic signed [W-1:0] HALF = W'(1) << (SHIFT - 1);

    logic                        w_adv;
    logic signed [2*BITSIZE-1:0] r_prod;
    logic        [CHW-1:0]       r_ch;
    logic                        r_rnd;
    logic                        r_s1_valid;
    logic signed [W-1:0]         w_sum;
    logic signed [W-1:0]         w_val;
    logic        [BITSIZE-1:0]   w_res;
    logic        [BITSIZE-1:0]   r_out;
    logic        [CHW-1:0]       r_out_ch;
    logic                        r_out_valid;

    // The whole pipe moves together: it only freezes when a result is waiting on downstream.
    assign w_adv        = bus.out_ready | ~r_out_valid;
    assign bus.in_ready = w_adv;

    // Rounding add is one bit wider than the product so it can never wrap.
    assign w_sum = W'(r_prod) + (r_rnd ? HALF : '0);
    assign w_val = w_sum >>> SHIFT;

`ifdef PIPE_MULTIPLIER_SATURATE_EN
    localparam logic signed [W-1:0] MAXV = (W'(1) << (BITSIZE - 1)) - W'(1);
    localparam logic signed [W-1:0] MINV = -(W'(1) << (BITSIZE - 1));

    logic w_hi;
    logic w_lo;
    logic w_sat;
    logic r_sat_flag;

    assign w_hi  = w_val > MAXV;
    assign w_lo  = w_val < MINV;
    assign w_sat = w_hi | w_lo;
    assign w_res = w_hi ? MAXV[BITSIZE-1:0] : w_lo ? MINV[BITSIZE-1:0] : w_val[BITSIZE-1:0];

    // Sticky overflow flag; a saturated result landing in S2 beats a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_sat_flag <= 1'b0;
        else if (w_adv && r_s1_valid && w_sat)
            r_sat_flag <= 1'b1;
        else if (bus.sat_clr)
            r_sat_flag <= 1'b0;
    end

    assign bus.sat_flag = r_sat_flag;
`else
    logic w_unused;

    assign w_unused     = ^{w_val[W-1:BITSIZE], bus.sat_clr};
    assign w_res        = w_val[BITSIZE-1:0];
    assign bus.sat_flag = 1'b0;
`endif

    // S1: capture the full-precision product with its tag and rounding mode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_prod     <= '0;
            r_ch       <= '0;
            r_rnd      <= 1'b0;
        end else if (w_adv) begin
            r_s1_valid <= bus.in_valid;
            r_prod     <= (2*BITSIZE)'(bus.in1) * (2*BITSIZE)'(bus.in2);
            r_ch       <= bus.in_ch;
            r_rnd      <= bus.round_en;
        end
    end

    // S2: present the shaped result; data/tag only change when a real result arrives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out       <= '0;
            r_out_ch    <= '0;
        end else if (w_adv) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out    <= w_res;
                r_out_ch <= r_ch;
            end
        end
    end

    assign bus.out       = r_out;
    assign bus.out_ch    = r_out_ch;
    assign bus.out_valid = r_out_valid;
endmodule

// File: tb/tb_pipe_multiplier.sv
// tb_pipe_multiplier: directed and randomized checks of pipe_multiplier against an arithmetic reference model
module tb_pipe_multiplier;
    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    pipe_multiplier_if #(.BITSIZE(16), .CHW(2)) ba ();
    pipe_multiplier_if #(.BITSIZE(16), .CHW(2)) bb ();

    pipe_multiplier #(.BITSIZE(16), .SHIFT(15), .CHW(2)) dut15 (.clk(clk), .rst(rst), .bus(ba));
    pipe_multiplier #(.BITSIZE(16), .SHIFT(16), .CHW(2)) dut16 (.clk(clk), .rst(rst), .bus(bb));

    // Reference: exact integer product, optional +2^(sh-1), floor shift, then clamp or wrap. Returns {sat, out}.
    function automatic logic [16:0] ref_mul(input logic [15:0] a, input logic [15:0] b, input logic rnd, input int sh);
        longint p;
        longint v;
        logic   s;
        p = longint'($signed(a)) * longint'($signed(b));
        if (rnd)
            p = p + (longint'(1) << (sh - 1));
        v = p >>> sh;
        s = 1'b0;
`ifdef PIPE_MULTIPLIER_SATURATE_EN
        if (v > 32767) begin
            v = 32767;
            s = 1'b1;
        end else if (v < -32768) begin
            v = -32768;
            s = 1'b1;
        end
`endif
        return {s, v[15:0]};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        {ba.in1, ba.in2, ba.in_ch, ba.in_valid, ba.round_en, ba.sat_clr} = '0;
        {bb.in1, bb.in2, bb.in_ch, bb.in_valid, bb.round_en, bb.sat_clr} = '0;
        ba.out_ready = 1'b1;
        bb.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total += 5;
        if (ba.out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", ba.out_valid); end
        if (ba.out !== 16'h0) begin bad++; $display("FAIL rst_out: got %h want 0000", ba.out); end
        if (ba.out_ch !== 2'd0) begin bad++; $display("FAIL rst_ch: got %0d want 0", ba.out_ch); end
        if (ba.sat_flag !== 1'b0) begin bad++; $display("FAIL rst_sat: got %b want 0", ba.sat_flag); end
        if (ba.in_ready !== 1'b1) begin bad++; $display("FAIL rst_ready: got %b want 1", ba.in_ready); end
        rst = 1'b0;
    endtask

    // First pair offered right after reset release; result must appear two cycles after acceptance.
    task automatic test_latency();
        bb.in1 = 16'h4000; bb.in2 = 16'h4000; bb.in_ch = 2'd1; bb.round_en = 1'b0; bb.in_valid = 1'b1;
        @(negedge clk);
        total++;
        if (bb.in_ready !== 1'b1) begin bad++; $display("FAIL lat_ready: got %b want 1", bb.in_ready); end
        @(posedge clk); #1;
        bb.in_valid = 1'b0;
        @(negedge clk);
        total++;
        if (bb.out_valid !== 1'b0) begin bad++; $display("FAIL lat_early: got valid %b want 0", bb.out_valid); end
        @(negedge clk);
        total += 3;
        if (bb.out_valid !== 1'b1) begin bad++; $display("FAIL lat_valid: got %b want 1", bb.out_valid); end
        if (bb.out !== 16'h1000) begin bad++; $display("FAIL lat_out: got %h want 1000", bb.out); end
        if (bb.out_ch !== 2'd1) begin bad++; $display("FAIL lat_ch: got %0d want 1", bb.out_ch); end
        @(negedge clk);
        total += 2;
        if (bb.out_valid !== 1'b0) begin bad++; $display("FAIL lat_dup: got valid %b want 0", bb.out_valid); end
        if (bb.out !== 16'h1000) begin bad++; $display("FAIL lat_hold: got %h want 1000", bb.out); end
        @(posedge clk); #1;
    endtask

    task automatic test_rounding();
        logic [15:0] a[3] = '{16'h0001, 16'h0001, 16'hFFFF};
        logic        r[3] = '{1'b1, 1'b0, 1'b1};
        logic [15:0] w[3] = '{16'h0001, 16'h0000, 16'h0000};
        for (int c = 0; c < 5; c++) begin
            ba.in_valid = c < 3;
            ba.in1      = a[c % 3];
            ba.in2      = 16'h4000;
            ba.round_en = r[c % 3];
            ba.in_ch    = 2'(c);
            @(negedge clk);
            if (c >= 2) begin
                total += 3;
                if (ba.out_valid !== 1'b1) begin bad++; $display("FAIL rnd_valid[%0d]: got %b want 1", c - 2, ba.out_valid); end
                if (ba.out !== w[c-2]) begin bad++; $display("FAIL rnd_out[%0d]: got %h want %h", c - 2, ba.out, w[c-2]); end
                if (ba.out_ch !== 2'(c - 2)) begin bad++; $display("FAIL rnd_ch[%0d]: got %0d want %0d", c - 2, ba.out_ch, c - 2); end
            end
            @(posedge clk); #1;
        end
        ba.in_valid = 1'b0;
    endtask

    // Two saturating pairs; clear coincides with the second one landing, then clear alone.
    task automatic test_saturation();
`ifdef PIPE_MULTIPLIER_SATURATE_EN
        logic [15:0] w = 16'h7FFF;
        logic        s = 1'b1;
`else
        logic [15:0] w = 16'h8000;
        logic        s = 1'b0;
`endif
        ba.in1 = 16'h8000; ba.in2 = 16'h8000; ba.round_en = 1'b0; ba.in_ch = 2'd2; ba.in_valid = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        ba.in_valid = 1'b0;
        ba.sat_clr  = 1'b1;
        @(negedge clk);
        total += 2;
        if (ba.out !== w) begin bad++; $display("FAIL sat_out: got %h want %h", ba.out, w); end
        if (ba.sat_flag !== s) begin bad++; $display("FAIL sat_set: got %b want %b", ba.sat_flag, s); end
        @(negedge clk);
        total += 2;
        if (ba.out !== w) begin bad++; $display("FAIL sat_out2: got %h want %h", ba.out, w); end
        if (ba.sat_flag !== s) begin bad++; $display("FAIL sat_set_wins: got %b want %b", ba.sat_flag, s); end
        @(negedge clk);
        total += 2;
        if (ba.sat_flag !== 1'b0) begin bad++; $display("FAIL sat_clr: got %b want 0", ba.sat_flag); end
        if (ba.out_valid !== 1'b0) begin bad++; $display("FAIL sat_bubble: got %b want 0", ba.out_valid); end
        @(posedge clk); #1;
        ba.sat_clr = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [17:0] q[$];
        logic [17:0] e;
        logic [16:0] r;
        logic [15:0] a[4];
        logic [15:0] b[4];
        int          idx = 0;
        int          got = 0;
        for (int i = 0; i < 4; i++) begin
            a[i] = 16'($urandom);
            b[i] = 16'($urandom);
        end
        ba.round_en = 1'b0;
        for (int c = 0; c < 14; c++) begin
            ba.out_ready = !(c >= 3 && c <= 5);
            ba.in_valid  = idx < 4;
            ba.in1       = a[idx % 4];
            ba.in2       = b[idx % 4];
            ba.in_ch     = 2'(idx);
            @(negedge clk);
            if (c >= 3 && c <= 5) begin
                total++;
                if (ba.in_ready !== 1'b0) begin bad++; $display("FAIL b2b_stall_ready[%0d]: got %b want 0", c, ba.in_ready); end
            end
            if (ba.in_valid && ba.in_ready) begin
                r = ref_mul(a[idx], b[idx], 1'b0, 15);
                q.push_back({2'(idx), r[15:0]});
                idx++;
            end
            if (ba.out_valid && ba.out_ready) begin
                total++;
                got++;
                e = 'x;
                if (q.size() != 0)
                    e = q.pop_front();
                if ({ba.out_ch, ba.out} !== e) begin bad++; $display("FAIL b2b_out[%0d]: got ch %0d %h want %h", got, ba.out_ch, ba.out, e); end
            end
            @(posedge clk); #1;
        end
        total++;
        if (got != 4 || q.size() != 0) begin bad++; $display("FAIL b2b_count: got %0d results want 4, %0d left", got, q.size()); end
    endtask

    task automatic test_random();
        logic [17:0] q[$];
        logic [17:0] e;
        logic [17:0] held = '0;
        logic [16:0] r;
        logic        stall = 1'b0;
        for (int c = 0; c < 400; c++) begin
            ba.in_valid  = (c < 380) && ($urandom_range(3) != 0);
            ba.out_ready = (c >= 380) || ($urandom_range(2) != 0);
            ba.in1       = 16'($urandom);
            ba.in2       = 16'($urandom);
            ba.round_en  = 1'($urandom);
            ba.in_ch     = 2'($urandom);
            @(negedge clk);
            total++;
            if (ba.in_ready !== (ba.out_ready || !ba.out_valid)) begin bad++; $display("FAIL rnd_ready[%0d]: got %b", c, ba.in_ready); end
            if (stall) begin
                total++;
                if ({ba.out_valid, ba.out_ch, ba.out} !== {1'b1, held}) begin bad++; $display("FAIL rnd_hold[%0d]: got %b %h want 1 %h", c, ba.out_valid, {ba.out_ch, ba.out}, held); end
            end
            if (ba.in_valid && ba.in_ready) begin
                r = ref_mul(ba.in1, ba.in2, ba.round_en, 15);
                q.push_back({ba.in_ch, r[15:0]});
            end
            stall = ba.out_valid && !ba.out_ready;
            held  = {ba.out_ch, ba.out};
            if (ba.out_valid && ba.out_ready) begin
                total++;
                e = 'x;
                if (q.size() != 0)
                    e = q.pop_front();
                if ({ba.out_ch, ba.out} !== e) begin bad++; $display("FAIL rnd_out[%0d]: got %h want %h", c, {ba.out_ch, ba.out}, e); end
            end
            @(posedge clk); #1;
        end
        ba.in_valid = 1'b0;
        total++;
        if (q.size() != 0) begin bad++; $display("FAIL rnd_drain: %0d results missing", q.size()); end
    endtask

    // Reset lands between clock edges while a result is stalled; it must vanish at once.
    task automatic test_reset_midstall();
        ba.in1 = 16'h8000; ba.in2 = 16'h8000; ba.round_en = 1'b0; ba.in_ch = 2'd3;
        ba.in_valid = 1'b1; ba.out_ready = 1'b0;
        @(posedge clk); #1;
        ba.in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if (ba.out_valid !== 1'b1) begin bad++; $display("FAIL rms_pre: got valid %b want 1", ba.out_valid); end
        #2 rst = 1'b1;
        #1;
        total += 5;
        if (ba.out_valid !== 1'b0) begin bad++; $display("FAIL rms_valid: got %b want 0", ba.out_valid); end
        if (ba.out !== 16'h0) begin bad++; $display("FAIL rms_out: got %h want 0000", ba.out); end
        if (ba.out_ch !== 2'd0) begin bad++; $display("FAIL rms_ch: got %0d want 0", ba.out_ch); end
        if (ba.sat_flag !== 1'b0) begin bad++; $display("FAIL rms_sat: got %b want 0", ba.sat_flag); end
        if (ba.in_ready !== 1'b1) begin bad++; $display("FAIL rms_ready: got %b want 1", ba.in_ready); end
        @(posedge clk); #1;
        rst = 1'b0;
        ba.out_ready = 1'b1;
        ba.in1 = 16'h0001; ba.in2 = 16'h4000; ba.round_en = 1'b1; ba.in_ch = 2'd2; ba.in_valid = 1'b1;
        @(posedge clk); #1;
        ba.in_valid = 1'b0;
        @(negedge clk);
        total++;
        if (ba.out_valid !== 1'b0) begin bad++; $display("FAIL rms_stale: got valid %b want 0", ba.out_valid); end
        @(negedge clk);
        total += 3;
        if (ba.out_valid !== 1'b1) begin bad++; $display("FAIL rms_next_valid: got %b want 1", ba.out_valid); end
        if (ba.out !== 16'h0001) begin bad++; $display("FAIL rms_next_out: got %h want 0001", ba.out); end
        if (ba.out_ch !== 2'd2) begin bad++; $display("FAIL rms_next_ch: got %0d want 2", ba.out_ch); end
        @(posedge clk); #1;
    endtask

    initial begin
        test_reset();
        test_latency();
        test_rounding();
        test_saturation();
        test_back_to_back();
        test_random();
        test_reset_midstall();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
